array_alloc_ctrl: RTL and testbench

- Arbitrated controller for the heap array-handle resource: freed-arrays stack, high-water allocation counter, per-array size table.
- Serves NREQ requesters with ALLOC / FREE / EXTEND / SIZE operations.
- Executes one operation at a time with round-robin fairness.
- Sits between the instruction sequencer(s) and heap addressing; the returned handle times NArea gives the heap base.

---
 rtl/array_alloc_ctrl_pkg.sv | 24 ++
 rtl/array_alloc_ctrl_if.sv | 36 +++
 rtl/array_alloc_ctrl_rr_arbiter.sv | 32 +++
 rtl/array_alloc_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_array_alloc_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/array_alloc_ctrl_pkg.sv
// array_alloc_pkg: shared types and constants for the array-handle allocator.
//   op_e    : request opcodes ALLOC / FREE / EXTEND / SIZE (2-bit encoding 0..3)
//   state_e : controller FSM states IDLE -> EXEC -> RESP
//   ELEM_W  : default width of handles, element indices and sizes
//   OP_W    : width of one requester's opcode field
package array_alloc_pkg;

    localparam int ELEM_W = 12;
    localparam int OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ALLOC  = 2'd0,
        OP_FREE   = 2'd1,
        OP_EXTEND = 2'd2,
        OP_SIZE   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/array_alloc_ctrl_if.sv
// array_alloc_ctrl_if: request/response bundle between NREQ requesters and
// the allocator.
//   req_valid  [NREQ]     request present per requester
//   req_op     [2*NREQ]   opcode per requester
//   req_handle [W*NREQ]   target handle per requester
//   req_index  [W*NREQ]   element index per requester (EXTEND)
//   req_ready  [NREQ]     one-hot grant
//   rsp_valid  [NREQ]     one-hot, one-cycle response strobe
//   rsp_data   [W]        handle (ALLOC) or size (SIZE), else 0
//   rsp_error  [1]        operation failed, qualified by rsp_valid
// Handshake: a request transfers at a rising edge where req_valid[i] and
// req_ready[i] are both high; the requester holds valid/op/handle/index
// stable until then. rsp_valid[i] is a strobe with no back-pressure.
interface array_alloc_ctrl_if #(
    parameter int NREQ = 2,
    parameter int W    = 12
);
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_handle;
    logic [W*NREQ-1:0] req_index;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              rsp_error;

    modport master (
        output req_valid, req_op, req_handle, req_index,
        input  req_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_op, req_handle, req_index,
        output req_ready, rsp_valid, rsp_data, rsp_error
    );
endinterface

// File: rtl/array_alloc_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       [NREQ] request bits
//   ptr       [PW]   first requester to consider
//   grant     [NREQ] one-hot winner (all zero when no request)
//   grant_idx [PW]   index of the winner
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx
);
    int   j;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!found && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = PW'(j);
                found     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/array_alloc_ctrl.sv
// array_alloc_ctrl: arbitrated heap array-handle allocator (freed-handle LIFO,
// high-water counter, per-handle size table). One operation at a time:
// accept (IDLE) -> execute (EXEC) -> respond (RESP).
//   clock, reset : clock and asynchronous active-high reset
//   bus          : array_alloc_ctrl_if.slave request/response bundle
//   allocs       : high-water count of handles ever issued
//   in_use       : allocs minus freed-stack depth
//   busy         : FSM not in IDLE
//   state_dbg    : current FSM state
// Optional feature macro ALLOC_TRACK_EN: adds a live bit per handle so FREE,
// EXTEND and SIZE on a handle that is not currently allocated are rejected.
module array_alloc_ctrl
    import array_alloc_pkg::*;
#(
    parameter int NREQ               = 2,
    parameter int NArrays            = 2000,
    parameter int MemoryElementWidth = ELEM_W
) (
    input  logic                          clock,
    input  logic                          reset,
    array_alloc_ctrl_if.slave             bus,
    output logic [MemoryElementWidth-1:0] allocs,
    output logic [MemoryElementWidth-1:0] in_use,
    output logic                          busy,
    output state_e                        state_dbg
);
    localparam int W  = MemoryElementWidth;
    localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [W-1:0]  N_ARR  = W'(NArrays);
    localparam logic [W-1:0]  ONE_W  = W'(1);
    localparam logic [PW-1:0] LAST_P = PW'(NREQ - 1);
    localparam logic [PW-1:0] ONE_P  = PW'(1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant, grant_q;
    logic [PW-1:0]   grant_idx, rr_ptr;
    op_e             op_q;
    logic [W-1:0]    handle_q, index_q, top_q, allocs_q;
    logic [W-1:0]    rsp_data_q;
    logic            rsp_error_q;
    logic [OP_W-1:0] sel_op;
    logic [W-1:0]    sel_handle, sel_index;

    // Neither memory is reset: ALLOC zeroes the size entry it hands out and
    // the stack is only read below its top.
    logic [W-1:0] size_mem  [NArrays];
    logic [W-1:0] freed_mem [NArrays];

    logic [AW-1:0] hidx, size_addr;
    logic [W-1:0]  top_m1, alloc_h, exec_data, size_wdata;
    logic [W:0]    idx_ext;
    logic          handle_ok, exec_error, push, pop, grow, size_we;

`ifdef ALLOC_TRACK_EN
    logic [NArrays-1:0] live_q;
`endif

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Winner's request fields.
    always_comb begin
        sel_op     = '0;
        sel_handle = '0;
        sel_index  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op     = bus.req_op[OP_W*i +: OP_W];
                sel_handle = bus.req_handle[W*i +: W];
                sel_index  = bus.req_index[W*i +: W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        case (state_q)
            ST_IDLE: if (|bus.req_valid) begin
                bus.req_ready = grant;
                state_d       = ST_EXEC;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operation decode for the EXEC cycle.
    always_comb begin
        hidx       = handle_q[AW-1:0];
        top_m1     = top_q - ONE_W;
        idx_ext    = {1'b0, index_q} + {{W{1'b0}}, 1'b1};
`ifdef ALLOC_TRACK_EN
        handle_ok  = (handle_q < allocs_q) && live_q[hidx];
`else
        handle_ok  = (handle_q < allocs_q);
`endif
        exec_error = 1'b0;
        exec_data  = '0;
        push       = 1'b0;
        pop        = 1'b0;
        grow       = 1'b0;
        size_we    = 1'b0;
        size_addr  = hidx;
        size_wdata = '0;
        alloc_h    = '0;
        case (op_q)
            OP_ALLOC: begin
                if (top_q != '0) begin
                    alloc_h = freed_mem[top_m1[AW-1:0]];
                    pop     = 1'b1;
                end else if (allocs_q < N_ARR) begin
                    alloc_h = allocs_q;
                    grow    = 1'b1;
                end else begin
                    exec_error = 1'b1;
                end
                if (!exec_error) begin
                    size_we   = 1'b1;
                    size_addr = alloc_h[AW-1:0];
                    exec_data = alloc_h;
                end
            end
            OP_FREE: begin
                if (!handle_ok) exec_error = 1'b1;
                else            push       = 1'b1;
            end
            OP_EXTEND: begin
                // index+1 is formed one bit wider so a carry out is an error.
                if (!handle_ok || idx_ext[W]) begin
                    exec_error = 1'b1;
                end else if (size_mem[hidx] < idx_ext[W-1:0]) begin
                    size_we    = 1'b1;
                    size_wdata = idx_ext[W-1:0];
                end
            end
            OP_SIZE: begin
                if (!handle_ok) exec_error = 1'b1;
                else            exec_data  = size_mem[hidx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_q     <= '0;
            rr_ptr      <= '0;
            op_q        <= OP_ALLOC;
            handle_q    <= '0;
            index_q     <= '0;
            top_q       <= '0;
            allocs_q    <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
`ifdef ALLOC_TRACK_EN
            live_q      <= '0;
`endif
        end else begin
            if (state_q == ST_IDLE && |bus.req_valid) begin
                grant_q  <= grant;
                op_q     <= op_e'(sel_op);
                handle_q <= sel_handle;
                index_q  <= sel_index;
                rr_ptr   <= (grant_idx == LAST_P) ? '0 : grant_idx + ONE_P;
            end
            if (state_q == ST_EXEC) begin
                rsp_data_q  <= exec_data;
                rsp_error_q <= exec_error;
                if (pop)  top_q    <= top_m1;
                if (push) top_q    <= top_q + ONE_W;
                if (grow) allocs_q <= allocs_q + ONE_W;
`ifdef ALLOC_TRACK_EN
                if (op_q == OP_ALLOC && !exec_error) live_q[alloc_h[AW-1:0]] <= 1'b1;
                if (op_q == OP_FREE  && !exec_error) live_q[hidx]            <= 1'b0;
`endif
            end
        end
    end

    // Memory writes; gated by reset so an op discarded by reset leaves no trace.
    always_ff @(posedge clock) begin
        if (!reset && state_q == ST_EXEC) begin
            if (size_we) size_mem[size_addr]        <= size_wdata;
            if (push)    freed_mem[top_q[AW-1:0]]   <= handle_q;
        end
    end

    assign bus.rsp_valid = (state_q == ST_RESP) ? grant_q : '0;
    assign bus.rsp_data  = (state_q == ST_RESP) ? rsp_data_q : '0;
    assign bus.rsp_error = (state_q == ST_RESP) && rsp_error_q;
    assign allocs        = allocs_q;
    assign in_use        = allocs_q - top_q;
    assign busy          = (state_q != ST_IDLE);
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_array_alloc_ctrl.sv
// tb_array_alloc_ctrl: directed test of array_alloc_ctrl with NArrays=4.
module tb_array_alloc_ctrl;
    import array_alloc_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 12;
    localparam int NARR = 4;

    logic         clock;
    logic         reset;
    logic [W-1:0] allocs, in_use;
    logic         busy;
    state_e       state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    array_alloc_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

    array_alloc_ctrl #(
        .NREQ(NREQ), .NArrays(NARR), .MemoryElementWidth(W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .allocs    (allocs),
        .in_use    (in_use),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_handle = '0;
        bus.req_index  = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // driver: one request from requester r, returns the response
    task automatic do_op(input int r, input op_e op, input logic [W-1:0] h,
                         input logic [W-1:0] idx, output logic [W-1:0] data,
                         output logic err);
        int waited;
        logic [NREQ-1:0] exp_onehot;
        waited     = 0;
        data       = '0;
        err        = 1'b0;
        exp_onehot = '0;
        exp_onehot[r] = 1'b1;
        @(negedge clock);
        bus.req_valid[r]          = 1'b1;
        bus.req_op[2*r +: 2]      = op;
        bus.req_handle[W*r +: W]  = h;
        bus.req_index[W*r +: W]   = idx;
        #1;
        while (!bus.req_ready[r] && waited < 20) begin
            @(negedge clock);
            #1;
            waited++;
        end
        check("ready_seen", 32'(waited < 20), 1);
        if (waited < 20) begin
            @(posedge clock);
            #1;
            bus.req_valid[r] = 1'b0;
            @(negedge clock);
            check("no_rsp_in_exec", 32'(bus.rsp_valid), 0);
            @(negedge clock);
            check("rsp_valid_latency2", 32'(bus.rsp_valid), 32'(exp_onehot));
            data = bus.rsp_data;
            err  = bus.rsp_error;
        end else begin
            bus.req_valid[r] = 1'b0;
        end
    endtask

    task automatic op_expect(input string tag, input int r, input op_e op,
                             input logic [W-1:0] h, input logic [W-1:0] idx,
                             input logic [W-1:0] exp_data, input logic exp_err);
        logic [W-1:0] d;
        logic e;
        do_op(r, op, h, idx, d, e);
        check({tag, "_data"}, 32'(d), 32'(exp_data));
        check({tag, "_err"}, 32'(e), 32'(exp_err));
    endtask

    initial begin
        logic [W-1:0] exp_q[$];
        int grants;
        int waited;
        int got;

        reset = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clock);
        #1;
        // reset state
        check("rst_allocs", 32'(allocs), 0);
        check("rst_in_use", 32'(in_use), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clock);
        reset = 1'b0;

        // ALLOC x3 -> 0,1,2
        op_expect("alloc0", 0, OP_ALLOC, 0, 0, 0, 0);
        op_expect("alloc1", 0, OP_ALLOC, 0, 0, 1, 0);
        op_expect("alloc2", 0, OP_ALLOC, 0, 0, 2, 0);
        check("allocs_3", 32'(allocs), 3);
        check("in_use_3", 32'(in_use), 3);

        // LIFO reuse
        op_expect("free1", 0, OP_FREE, 1, 0, 0, 0);
        op_expect("free2", 1, OP_FREE, 2, 0, 0, 0);
        check("in_use_1", 32'(in_use), 1);
        op_expect("realloc2", 0, OP_ALLOC, 0, 0, 2, 0);
        op_expect("realloc1", 1, OP_ALLOC, 0, 0, 1, 0);
        check("allocs_still_3", 32'(allocs), 3);
        check("in_use_back_3", 32'(in_use), 3);

        // EXTEND / SIZE on handle 0
        op_expect("ext_i0", 0, OP_EXTEND, 0, 0, 0, 0);
        op_expect("ext_i1", 0, OP_EXTEND, 0, 1, 0, 0);
        op_expect("ext_i0_again", 1, OP_EXTEND, 0, 0, 0, 0);
        op_expect("size_h0", 0, OP_SIZE, 0, 0, 2, 0);
        op_expect("free0", 0, OP_FREE, 0, 0, 0, 0);
        op_expect("realloc0", 0, OP_ALLOC, 0, 0, 0, 0);
        op_expect("size_h0_zeroed", 0, OP_SIZE, 0, 0, 0, 0);

        // capacity and range boundaries
        op_expect("alloc3", 0, OP_ALLOC, 0, 0, 3, 0);
        check("allocs_full", 32'(allocs), 4);
        op_expect("alloc_full", 0, OP_ALLOC, 0, 0, 0, 1);
        check("allocs_unchanged", 32'(allocs), 4);
        op_expect("size_h7", 1, OP_SIZE, 7, 0, 0, 1);
        op_expect("free_h5", 0, OP_FREE, 5, 0, 0, 1);
        op_expect("ext_overflow", 0, OP_EXTEND, 0, 12'hFFF, 0, 1);
        op_expect("ext_max_ok", 0, OP_EXTEND, 3, 12'hFFE, 0, 0);
        op_expect("size_h3_max", 1, OP_SIZE, 3, 0, 12'hFFF, 0);
        op_expect("size_h0_after_ovf", 0, OP_SIZE, 0, 0, 0, 0);

        // reset during EXEC of an ALLOC
        @(negedge clock);
        bus.req_valid[0]  = 1'b1;
        bus.req_op[1:0]   = OP_ALLOC;
        #1;
        check("mid_rst_ready", 32'(bus.req_ready), 1);
        @(posedge clock);
        #1;
        bus.req_valid[0] = 1'b0;
        check("mid_rst_in_exec", 32'(state_dbg), 32'(ST_EXEC));
        reset = 1'b1;
        #1;
        check("mid_rst_allocs", 32'(allocs), 0);
        check("mid_rst_busy", 32'(busy), 0);
        @(negedge clock);
        check("mid_rst_no_rsp_a", 32'(bus.rsp_valid), 0);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_no_rsp_b", 32'(bus.rsp_valid), 0);
        @(negedge clock);
        check("mid_rst_no_rsp_c", 32'(bus.rsp_valid), 0);
        op_expect("post_rst_alloc", 0, OP_ALLOC, 0, 0, 0, 0);

        // fairness: both requesters valid every cycle
        do_reset();
        exp_q = '{12'd0, 12'd1, 12'd0, 12'd1};
        bus.req_op    = {OP_ALLOC, OP_ALLOC};
        bus.req_valid = 2'b11;
        grants = 0;
        waited = 0;
        while (grants < 4 && waited < 40) begin
            #1;
            if (bus.req_ready != '0) begin
                got = (bus.req_ready == 2'b10) ? 1 : 0;
                check("rr_onehot", 32'($countones(bus.req_ready)), 1);
                check("rr_order", 32'(got), 32'(exp_q.pop_front()));
                grants++;
            end
            @(negedge clock);
            waited++;
        end
        check("rr_grants_done", 32'(grants), 4);
        // the last grant is accepted at the posedge after it was seen
        bus.req_valid = '0;
        repeat (4) @(negedge clock);
        check("rr_allocs", 32'(allocs), 4);

        // double FREE
        do_reset();
        op_expect("df_alloc0", 0, OP_ALLOC, 0, 0, 0, 0);
        op_expect("df_alloc1", 0, OP_ALLOC, 0, 0, 1, 0);
        op_expect("df_free0", 0, OP_FREE, 0, 0, 0, 0);
`ifdef ALLOC_TRACK_EN
        op_expect("df_free0_again", 1, OP_FREE, 0, 0, 0, 1);
        check("df_in_use", 32'(in_use), 1);
        op_expect("df_size_freed", 0, OP_SIZE, 0, 0, 0, 1);
`else
        op_expect("df_free0_again", 1, OP_FREE, 0, 0, 0, 0);
        check("df_in_use", 32'(in_use), 0);
`endif
        op_expect("df_realloc0", 0, OP_ALLOC, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
